// File: rtl/mem_bus_responder_pkg.sv
// Shared defines for the memory-side bus responder: reset/stall levels,
// register-bus widths, responder state encodings and the ack timeout default.
package mem_bus_responder_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;
  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;

  localparam int unsigned RegBus   = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam int unsigned StallW            = 6;
  localparam int unsigned SelW              = 4;
  localparam int unsigned BusTimeoutDefault = 255;

  typedef enum logic [1:0] {
    BusIdle = 2'd0,
    BusBusy = 2'd1,
    BusHold = 2'd2
  } bus_state_e;

endpackage

// File: rtl/mem_bus_responder.sv
// Turns memory-stage load/store requests into cyc/stb/ack bus transactions,
// stalls the pipeline until completion and aborts on a missing ack.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = RegBus,
  parameter int unsigned TIMEOUT = BusTimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stallreq_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  bus_state_e        state;
  logic [DATA_W-1:0] rd_buf;
  logic [CNT_W-1:0]  cnt;

  // Only the memory-stage bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Request FSM with registered bus outputs and inline saturating ack timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BusIdle;
      rd_buf      <= '0;
      cnt         <= '0;
      bus_cyc_o   <= 1'b0;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        BusIdle: begin
          if (mem_ce_i) begin
            bus_cyc_o   <= 1'b1;
            bus_stb_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_sel_o   <= mem_sel_i;
            bus_wdata_o <= mem_data_i;
            cnt         <= '0;
            state       <= BusBusy;
          end
        end
        BusBusy: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          // A late ack on the terminal cycle still completes normally.
          if (bus_ack_i) begin
            rd_buf    <= bus_we_o ? '0 : bus_rdata_i;
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            state     <= BusHold;
          end else if (cnt == CNT_LAST) begin
            rd_buf    <= '0;
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= BusHold;
          end
        end
        BusHold: begin
          if (stall[4] == NoStop) state <= BusIdle;
        end
        default: state <= BusIdle;
      endcase
    end
  end

  // Stall must rise in the request cycle itself, so it is decoded combinationally.
  assign stallreq_o = !rst && (((state == BusIdle) && mem_ce_i) || (state == BusBusy));
  assign mem_data_o = (state == BusHold) ? rd_buf : '0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: one long-timeout instance and one
// with a 4-cycle timeout, checked against a transaction-level expectation model.
module tb_mem_bus_responder;

  localparam int TMO_A = 255;
  localparam int TMO_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_sel;
  logic [1:0]  ack;

  logic [31:0] data_o [2];
  logic [31:0] baddr  [2];
  logic [31:0] bwdata [2];
  logic [3:0]  bsel   [2];
  logic        stallreq [2];
  logic        cyc [2];
  logic        stb [2];
  logic        bwe [2];
  logic        err [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO_A)) u_a (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_sel_i(mem_sel), .mem_data_i(mem_wdata), .mem_data_o(data_o[0]),
    .stallreq_o(stallreq[0]), .bus_cyc_o(cyc[0]), .bus_stb_o(stb[0]),
    .bus_we_o(bwe[0]), .bus_addr_o(baddr[0]), .bus_sel_o(bsel[0]),
    .bus_wdata_o(bwdata[0]), .bus_rdata_i(rdata), .bus_ack_i(ack[0]),
    .bus_err_o(err[0])
  );

  mem_bus_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO_B)) u_b (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_sel_i(mem_sel), .mem_data_i(mem_wdata), .mem_data_o(data_o[1]),
    .stallreq_o(stallreq[1]), .bus_cyc_o(cyc[1]), .bus_stb_o(stb[1]),
    .bus_we_o(bwe[1]), .bus_addr_o(baddr[1]), .bus_sel_o(bsel[1]),
    .bus_wdata_o(bwdata[1]), .bus_rdata_i(rdata), .bus_ack_i(ack[1]),
    .bus_err_o(err[1])
  );

  function automatic int tmo_of(input int k);
    return (k == 1) ? TMO_B : TMO_A;
  endfunction

  // Resets both instances and returns on a negedge with the bus quiet.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 6'b0; mem_ce = 1'b0; mem_we = 1'b0; ack = 2'b00;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0; rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One complete transaction starting in IDLE at the current negedge.
  // ack_at: BUSY cycle (1-based) in which ack is driven; 0 = never.
  task automatic run_txn(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [3:0] sel, input int ack_at,
                         input int hold_n, input bit scramble);
    int busy, exp_busy;
    bit done, ok_ack, exp_err;
    logic [31:0] exp_data;
    ok_ack   = (ack_at >= 1) && (ack_at <= tmo_of(k));
    exp_busy = ok_ack ? ack_at : tmo_of(k);
    exp_err  = !ok_ack;
    exp_data = (ok_ack && !we) ? rd : 32'h0;

    mem_ce = 1'b1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wd;
    stall = 6'b0; ack[k] = 1'b0; rdata = $urandom;
    #1;
    total++;
    if ({stallreq[k], cyc[k], data_o[k]} !== {1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL t0_request k=%0d got stallreq=%b cyc=%b data=%h exp 1 0 0",
               k, stallreq[k], cyc[k], data_o[k]);
    end

    busy = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (cyc[k]) begin
        busy++;
        total++;
        if ({stb[k], bwe[k], baddr[k], bsel[k], bwdata[k], stallreq[k], data_o[k], err[k]} !==
            {1'b1, we, addr, sel, wd, 1'b1, 32'h0, 1'b0}) begin
          bad++;
          $display("FAIL busy_bus k=%0d cyc=%0d got stb=%b we=%b a=%h s=%h w=%h sr=%b d=%h e=%b exp stb=1 we=%b a=%h s=%h w=%h sr=1 d=0 e=0",
                   k, busy, stb[k], bwe[k], baddr[k], bsel[k], bwdata[k], stallreq[k],
                   data_o[k], err[k], we, addr, sel, wd);
        end
        if (scramble) begin
          mem_we = ~we; mem_addr = $urandom; mem_sel = 4'($urandom); mem_wdata = $urandom;
        end
        stall  = {1'b0, 1'b1, 4'($urandom)};
        ack[k] = (busy == ack_at);
        rdata  = ack[k] ? rd : $urandom;
      end else begin
        done = 1'b1;
      end
    end
    ack[k] = 1'b0;
    if (!done) begin
      bad++;
      $display("FAIL busy_bound k=%0d got cyc still high after 300 cycles exp release", k);
      return;
    end

    total++;
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL busy_len k=%0d got=%0d exp=%0d", k, busy, exp_busy);
    end
    total++;
    if ({stallreq[k], stb[k], data_o[k], err[k]} !== {1'b0, 1'b0, exp_data, exp_err}) begin
      bad++;
      $display("FAIL hold_entry k=%0d got sr=%b stb=%b d=%h e=%b exp sr=0 stb=0 d=%h e=%b",
               k, stallreq[k], stb[k], data_o[k], err[k], exp_data, exp_err);
    end

    // Held by an external stall with the request still asserted; stray acks ignored.
    for (int j = 0; j < hold_n; j++) begin
      stall  = 6'b011111;
      ack[k] = 1'($urandom);
      rdata  = $urandom;
      @(negedge clk);
      total++;
      if ({cyc[k], stb[k], stallreq[k], data_o[k], err[k]} !== {1'b0, 1'b0, 1'b0, exp_data, 1'b0}) begin
        bad++;
        $display("FAIL hold_stall k=%0d cyc=%0d got c=%b stb=%b sr=%b d=%h e=%b exp 0 0 0 %h 0",
                 k, j, cyc[k], stb[k], stallreq[k], data_o[k], err[k], exp_data);
      end
    end

    stall = 6'b0; mem_ce = 1'b0; ack[k] = 1'b0;
    @(negedge clk);
    total++;
    if ({cyc[k], stallreq[k], data_o[k], err[k]} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL idle_return k=%0d got c=%b sr=%b d=%h e=%b exp 0 0 0 0",
               k, cyc[k], stallreq[k], data_o[k], err[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'b0; mem_ce = 1'b1; mem_we = 1'b1; ack = 2'b11;
    mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'hFFFF_FFFF; mem_sel = 4'hF; rdata = 32'hA5A5_A5A5;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({cyc[k], stb[k], bwe[k], baddr[k], bsel[k], bwdata[k], err[k], stallreq[k], data_o[k]} !== '0) begin
        bad++;
        $display("FAIL reset_state k=%0d got c=%b s=%b we=%b a=%h sel=%h w=%h e=%b sr=%b d=%h exp all 0",
                 k, cyc[k], stb[k], bwe[k], baddr[k], bsel[k], bwdata[k], err[k], stallreq[k], data_o[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_load();
    do_reset();
    run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 4'hF, 1, 0, 1'b0);
  endtask

  task automatic test_store();
    do_reset();
    run_txn(0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hCAFE_F00D, 4'h3, 5, 0, 1'b1);
  endtask

  task automatic test_timeout();
    do_reset();
    run_txn(1, 1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 4'hF, 0, 0, 1'b0);
  endtask

  task automatic test_hold_stall();
    do_reset();
    run_txn(0, 1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 4'hC, 2, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_txn(0, 1'b0, 32'h0000_0080, 32'h0, 32'h1111_2222, 4'hF, 1, 0, 1'b0);
    run_txn(0, 1'b1, 32'h0000_0084, 32'h3333_4444, 32'h0, 4'h1, 2, 1, 1'b0);
    run_txn(0, 1'b0, 32'h0000_0088, 32'h0, 32'h5555_6666, 4'h6, 3, 0, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0200; mem_sel = 4'hF;
    repeat (2) @(negedge clk);
    total++;
    if (cyc[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_busy got cyc=%b exp 1", cyc[0]);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({cyc[0], stb[0], stallreq[0]} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset_drop got c=%b s=%b sr=%b exp 0 0 0", cyc[0], stb[0], stallreq[0]);
    end
    mem_ce = 1'b0;
    @(negedge clk);
    rst = 1'b0; ack[0] = 1'b1; rdata = 32'h7777_8888;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ack[0] = 1'b0;
      total++;
      if ({cyc[0], stallreq[0], data_o[0], err[0]} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL post_reset_ack cyc=%0d got c=%b sr=%b d=%h e=%b exp 0 0 0 0",
                 i, cyc[0], stallreq[0], data_o[0], err[0]);
      end
    end
  endtask

  task automatic test_stray_ack();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ack[0] = 1'b1; rdata = $urandom;
      @(negedge clk);
      total++;
      if ({cyc[0], stallreq[0], data_o[0], err[0]} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL stray_ack cyc=%0d got c=%b sr=%b d=%h e=%b exp 0 0 0 0",
                 i, cyc[0], stallreq[0], data_o[0], err[0]);
      end
    end
    ack[0] = 1'b0;
    run_txn(0, 1'b0, 32'h0000_0300, 32'h0, 32'h9ABC_DEF0, 4'hF, 2, 0, 1'b0);
  endtask

  task automatic test_coincide();
    do_reset();
    run_txn(1, 1'b0, 32'h0000_0400, 32'h0, 32'hFEED_FACE, 4'hF, TMO_B, 1, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(0, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
              int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), 1'($urandom));
    end
    do_reset();
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      run_txn(1, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid_busy();
    test_stray_ack();
    test_coincide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion exp finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side counterpart to the EX/MEM pipeline register: accepts load/store requests that the memory stage derives from the mem_aluop/mem_mem_addr/mem_reg2 fields and turns them into multi-cycle transactions on a simple cyc/stb/ack data bus.
- Raises a stall request to ctrl until the transaction completes, then holds the result stable until the pipeline advances past the memory stage.
- Adds an ack timeout so a dead slave cannot hang the core.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, data width (equals RegBus)
- TIMEOUT, 255, max cycles in BUSY without ack before abort (range 2..1023)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  6  pipeline stall vector from ctrl; bit 4 = memory stage
- mem_ce_i  in  1  memory access request from memory stage
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  ADDR_W  byte address
- mem_sel_i  in  4  byte lane select
- mem_data_i  in  DATA_W  store data
- mem_data_o  out  DATA_W  load data returned to memory stage
- stallreq_o  out  1  stall request to ctrl
- bus_cyc_o  out  1  bus cycle active
- bus_stb_o  out  1  strobe, equal to bus_cyc_o
- bus_we_o  out  1  bus write enable
- bus_addr_o  out  ADDR_W  bus address
- bus_sel_o  out  4  bus byte select
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data
- bus_ack_i  in  1  slave acknowledge, single-cycle pulse
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - All bus_* outputs, rd_buf, timeout counter and bus_err_o = 0.
  - mem_data_o = 0, stallreq_o = 0.
  - Reset mid-transaction drops cyc/stb immediately; no completion is reported.
- States: IDLE, BUSY, HOLD.
- IDLE:
  - If mem_ce_i=1: next edge registers bus_cyc/stb=1 and copies we/addr/sel/wdata from mem_*_i. Counter cleared; state -> BUSY.
  - stallreq_o is combinational: 1 in IDLE when mem_ce_i=1, otherwise 0 in IDLE.
- BUSY:
  - stallreq_o = 1. Bus outputs held constant.
  - Counter increments each cycle.
  - On bus_ack_i=1: rd_buf <= bus_rdata_i for a load, 0 for a store; cyc/stb <= 0; state -> HOLD.
  - Timeout: counter == TIMEOUT-1 with no ack -> rd_buf <= 0, cyc/stb <= 0, bus_err_o pulses 1 for one cycle, state -> HOLD.
  - Ack and terminal count in the same cycle: ack wins, no bus_err_o.
- HOLD:
  - stallreq_o = 0; mem_data_o = rd_buf.
  - If stall[4]=0 (memory stage advances this edge), state -> IDLE.
  - If stall[4]=1 (stall from another source), stay in HOLD; no reissue while mem_ce_i stays high.
- mem_data_o = rd_buf in HOLD, 0 in IDLE and BUSY.
- bus_ack_i in IDLE or HOLD is ignored (stray ack).
- Latency: request seen in cycle T0, stb high from T1. Ack in T1 gives HOLD at T2. Minimum 2 stall cycles; the memory stage sees data in the first cycle stallreq_o=0.
- mem_*_i changes while BUSY are ignored; the captured request is completed.
- Back-to-back requests: the new request is recognised in IDLE on the cycle after HOLD exits.
- Counter width = clog2(TIMEOUT)+1; counter saturates, never wraps.

Decomposition:
- Shared defines file (existing): RstEnable, Stop/NoStop, ZeroWord, RegBus widths; add state encodings BusIdle/BusBusy/BusHold and the TIMEOUT default.
- No sub-module; the timeout counter is inline.

Test Plan:
- Load, ack 1 cycle after stb: mem_ce_i=1, we=0, addr=0x0000_0010, sel=4'hF, bus_rdata_i=0xDEAD_BEEF. Expect stb high T1, stallreq_o=1 for T0–T2 edge, HOLD at T2 with mem_data_o=0xDEADBEEF, stallreq_o=0, IDLE at T3 (stall=0).
- Store, ack after 5 cycles: wdata=0x1234_5678, sel=4'h3. Expect bus_we_o=1 and wdata/sel stable for all 5 BUSY cycles; mem_data_o=0 in HOLD.
- Timeout, TIMEOUT=4, no ack: expect cyc drops after 4 BUSY cycles, bus_err_o=1 for exactly one cycle, mem_data_o=0, stallreq_o released.
- External stall in HOLD, stall=6'b011111 for 3 cycles: expect state held in HOLD, mem_data_o stable, no second stb; IDLE after stall returns to 0.
- Async reset mid-BUSY at cycle 2: expect immediate cyc/stb=0 and stallreq_o=0 without a clock edge; a later ack is ignored.
- Stray ack in IDLE, plus ack coinciding with the terminal count: expect no state change for the stray ack; ack data captured and bus_err_o=0 for the coincidence.
